// File: rtl/reply_arbiter_if.sv
// reply_arbiter_if: requester lanes plus the single reply byte stream.
// Handshake: a byte moves on a lane or on the reply stream only in a cycle where
// its valid (req_rdy[i] / reply_rdy) and its accept (req_ack[i] / reply_ack) are both 1.
// The arbiter drives reply_rdy, reply and reply_end combinationally from the granted
// lane, and req_ack[i] is exactly that lane's reply transfer. Valid is not retracted
// by the arbiter itself; it follows the granted requester's req_rdy.
interface reply_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_rdy;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ack;
    logic               reply_rdy;
    logic [7:0]         reply;
    logic               reply_ack;
    logic               reply_end;

    // Arbiter side.
    modport master (
        input  req_rdy, req_data, req_last, reply_ack,
        output req_ack, reply_rdy, reply, reply_end
    );

    // Requesters plus host side.
    modport slave (
        output req_rdy, req_data, req_last, reply_ack,
        input  req_ack, reply_rdy, reply, reply_end
    );
endinterface

// File: rtl/reply_arbiter.sv
// reply_arbiter: round-robin, packet-granular sharing of the host reply byte stream
// among N_REQ requesters. A requester keeps the grant until its last byte is taken,
// or until it stalls for TIMEOUT consecutive cycles mid-packet (TIMEOUT=0 disables).
// Optional feature macro REPLY_TAG_EN: each packet is preceded by a tag byte
// {4'hF, grant_id} so the host can demultiplex; without it the stream is raw bytes.
module reply_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    reply_arbiter_if.master bus,
    output logic [ID_W-1:0] grant_id,
    output logic            stall_abort,
    output logic [1:0]      o_dbg_state
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

`ifdef REPLY_TAG_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TAG = 2'd1, ST_XFER = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  w_grant_next;
    logic [ID_W-1:0]  w_rr_pick;
    logic [ID_W-1:0]  w_rr_idx;
    logic             w_rr_found;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_next;
    logic             r_abort;
    logic             w_abort_next;
    logic             w_lane_rdy;
    logic             w_lane_last;
    logic [7:0]       w_lane_data;

    assign grant_id    = r_grant;
    assign stall_abort = r_abort;
    assign o_dbg_state = r_state;

    // Lane currently owned by the grant.
    assign w_lane_rdy  = bus.req_rdy[r_grant];
    assign w_lane_last = bus.req_last[r_grant];
    assign w_lane_data = bus.req_data[{r_grant, 3'b000} +: 8];

    // Round-robin search: first pending requester after the last grant, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = r_grant;
        w_rr_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_rr_idx = ID_W'((int'(r_grant) + k) % N_REQ);
            if (!w_rr_found && bus.req_rdy[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_rr_idx;
            end
        end
    end

    // Next-state and reply stream outputs; the stream is a zero-latency mux of the granted lane.
    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_stall_cnt_next = r_stall_cnt;
        w_abort_next     = 1'b0;
        bus.reply_rdy    = 1'b0;
        bus.reply        = '0;
        bus.reply_end    = 1'b0;
        bus.req_ack      = '0;
        case (r_state)
            ST_IDLE: begin
                w_stall_cnt_next = '0;
                if (w_rr_found) begin
                    w_grant_next = w_rr_pick;
`ifdef REPLY_TAG_EN
                    w_state_next = ST_TAG;
`else
                    w_state_next = ST_XFER;
`endif
                end
            end
`ifdef REPLY_TAG_EN
            ST_TAG: begin
                bus.reply_rdy = 1'b1;
                bus.reply     = 8'hF0 | 8'(r_grant);
                if (bus.reply_ack) begin
                    w_state_next = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                bus.reply     = w_lane_data;
                bus.reply_rdy = w_lane_rdy;
                bus.reply_end = w_lane_rdy & w_lane_last;
                if (w_lane_rdy && bus.reply_ack) begin
                    bus.req_ack[r_grant] = 1'b1;
                    w_stall_cnt_next     = '0;
                    if (w_lane_last) begin
                        w_state_next = ST_IDLE;
                    end
                end else if (!w_lane_rdy && (TIMEOUT != 0)) begin
                    // The requester is starving the host; drop the packet once patience runs out.
                    if (r_stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_state_next     = ST_IDLE;
                        w_abort_next     = 1'b1;
                        w_stall_cnt_next = '0;
                    end else begin
                        w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, grant and stall counter registers; grant resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= ID_W'(N_REQ - 1);
            r_stall_cnt <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_abort     <= w_abort_next;
        end
    end
endmodule

// File: tb/tb_reply_arbiter.sv
// tb_reply_arbiter: randomized and directed traffic against a packet-level reference
// of the round-robin reply arbiter, with a scoreboard of expected reply bytes.
module tb_reply_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TO   = 8;
  localparam int W    = ID_W + 9;
`ifdef REPLY_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [ID_W-1:0] grant_id;
  logic stall_abort;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  reply_arbiter_if #(.N_REQ(N)) bus ();

  reply_arbiter #(.N_REQ(N), .ID_W(ID_W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .grant_id    (grant_id),
    .stall_abort (stall_abort),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [8:0] lane_q[N][$];     // {last, byte} per requester, front = byte on the lane
  bit hold[N];
  int stall_after[N];
  int ack_cnt[N];
  int gap_pct = 0;
  int ack_pct = 100;
  bit stab_chk = 1'b0;
  int grant_log[$];

  // reference model state
  bit m_on = 1'b0;
  bit m_busy = 1'b0;
  bit m_tag = 1'b0;
  logic [ID_W-1:0] m_owner = '0;
  logic [ID_W-1:0] m_last = '0;
  int m_rem = 0;
  int m_stall = 0;
  bit m_abort_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic bit lanes_empty();
    for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req, input logic [ID_W-1:0] last);
    logic [ID_W-1:0] idx;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last) + k) % N);
      if (req[idx]) return idx;
    end
    return last;
  endfunction

  task automatic push_pkt(input int lane, input int len);
    logic [8:0] e;
    for (int j = 0; j < len; j++) begin
      e = {(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
      lane_q[lane].push_back(e);
    end
  endtask

  // ---------------- requester + host drivers ----------------
  initial begin
    logic [N-1:0] ack_seen;
    bit rst_seen;
    bus.req_rdy   = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.reply_ack = 1'b0;
    forever begin
      @(negedge clk);
      ack_seen = bus.req_ack;
      rst_seen = reset;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_seen) begin
          lane_q[i].delete();
          hold[i] = 1'b0;
          ack_cnt[i] = 0;
          stall_after[i] = 0;
        end else if (ack_seen[i] === 1'b1 && lane_q[i].size() > 0) begin
          void'(lane_q[i].pop_front());
          ack_cnt[i]++;
          if (ack_cnt[i] == stall_after[i]) hold[i] = 1'b1;
        end
        if (lane_q[i].size() > 0 && !hold[i] && int'($urandom_range(99)) >= gap_pct) begin
          bus.req_rdy[i] = 1'b1;
          bus.req_data[8*i +: 8] = lane_q[i][0][7:0];
          bus.req_last[i] = lane_q[i][0][8];
        end else begin
          bus.req_rdy[i] = 1'b0;
          bus.req_data[8*i +: 8] = 8'($urandom);
          bus.req_last[i] = 1'($urandom);
        end
      end
      bus.reply_ack = (int'($urandom_range(99)) < ack_pct);
    end
  end

  // ---------------- reference model: per-cycle expectations + expected byte stream ----------------
  initial begin
    bit exp_rdy, exp_end, xfer;
    logic [N-1:0] exp_ack;
    logic [ID_W-1:0] o;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      exp_rdy = 1'b0;
      exp_end = 1'b0;
      if (m_busy) begin
        exp_rdy = m_tag ? 1'b1 : bus.req_rdy[m_owner];
        exp_end = !m_tag && bus.req_rdy[m_owner] && bus.req_last[m_owner];
      end
      xfer = exp_rdy && bus.reply_ack;
      exp_ack = '0;
      if (xfer && !m_tag) exp_ack[m_owner] = 1'b1;
      if (m_on) begin
        check("reply_rdy", 32'(bus.reply_rdy), 32'(exp_rdy));
        check("reply_end", 32'(bus.reply_end), 32'(exp_end));
        check("req_ack", 32'(bus.req_ack), 32'(exp_ack));
        check("grant_id", 32'(grant_id), 32'(m_last));
        check("stall_abort", 32'(stall_abort), 32'(m_abort_exp));
      end
      m_abort_exp = 1'b0;
      if (reset) begin
        m_on = 1'b1;
        m_busy = 1'b0;
        m_tag = 1'b0;
        m_last = ID_W'(N - 1);
        m_rem = 0;
        m_stall = 0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (bus.req_rdy != '0) begin
          o = rr_pick(bus.req_rdy, m_last);
          grant_log.push_back(int'(o));
          m_busy = 1'b1;
          m_owner = o;
          m_last = o;
          m_tag = TAG_EN;
          m_stall = 0;
          m_rem = 0;
          if (TAG_EN) exp_q.push_back({o, 1'b0, 8'hF0 | 8'(o)});
          for (int j = 0; j < lane_q[o].size(); j++) begin
            e = lane_q[o][j];
            exp_q.push_back({o, e});
            m_rem++;
            if (e[8]) break;
          end
        end
      end else if (m_tag) begin
        if (xfer) m_tag = 1'b0;
      end else if (xfer) begin
        m_stall = 0;
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end else if (!bus.req_rdy[m_owner]) begin
        m_stall++;
        if (m_stall == TO) begin
          m_busy = 1'b0;
          m_abort_exp = 1'b1;
          m_stall = 0;
          repeat (m_rem) void'(exp_q.pop_back());
          m_rem = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp_e;
    bit prev_hold = 1'b0;
    logic [7:0] prev_byte = '0;
    forever begin
      @(negedge clk);
      if (stab_chk && prev_hold) begin
        check("hold_rdy", 32'(bus.reply_rdy), 32'(1'b1));
        check("hold_byte", 32'(bus.reply), 32'(prev_byte));
      end
      prev_hold = (bus.reply_rdy === 1'b1) && (bus.reply_ack === 1'b0);
      prev_byte = bus.reply;
      if (bus.reply_rdy === 1'b1 && bus.reply_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_byte actual=%0h required=none t=%0t", bus.reply, $time);
        end else begin
          exp_e = exp_q.pop_front();
          check("reply_byte", 32'({grant_id, bus.reply_end, bus.reply}), 32'(exp_e));
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(lanes_empty() && !m_busy && exp_q.size() == 0)) begin
      tick(1);
      n++;
    end
    check({name, "_drain"}, 32'(n < budget), 32'(1'b1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // idle after reset
    tick(10);
    check("t1_grant", 32'(grant_id), 32'(N - 1));
    check("t1_reply", 32'(bus.reply), 32'(0));
    check("t1_rdy", 32'(bus.reply_rdy), 32'(0));

    // single 3-byte packet on requester 2
    grant_log.delete();
    lane_q[2].push_back({1'b0, 8'h11});
    lane_q[2].push_back({1'b0, 8'h22});
    lane_q[2].push_back({1'b1, 8'h33});
    drain("t2", 200);
    check("t2_ngrants", 32'(grant_log.size()), 32'(1));
    if (grant_log.size() > 0) check("t2_owner", 32'(grant_log[0]), 32'(2));

    // fairness: 0 (twice), 1, 3 pending together after reset
    do_reset();
    grant_log.delete();
    push_pkt(0, 2);
    push_pkt(0, 2);
    push_pkt(1, 2);
    push_pkt(3, 2);
    drain("t3", 300);
    check("t3_ngrants", 32'(grant_log.size()), 32'(4));
    if (grant_log.size() == 4) begin
      check("t3_g0", 32'(grant_log[0]), 32'(0));
      check("t3_g1", 32'(grant_log[1]), 32'(1));
      check("t3_g2", 32'(grant_log[2]), 32'(3));
      check("t3_g3", 32'(grant_log[3]), 32'(0));
    end

    // random backpressure during a 5-byte packet, reply must hold steady
    ack_pct = 50;
    stab_chk = 1'b1;
    push_pkt(1, 5);
    drain("t4", 400);
    stab_chk = 1'b0;
    ack_pct = 100;

    // timeout: requester 1 stalls after its first byte, requester 2 waits
    do_reset();
    grant_log.delete();
    stall_after[1] = 1;
    push_pkt(1, 3);
    push_pkt(2, 2);
    n = 0;
    while (n < 60 && stall_abort !== 1'b1) begin
      tick(1);
      n++;
    end
    check("t5_abort_seen", 32'(n < 60), 32'(1'b1));
    check("t5_state_idle", 32'(dbg_state), 32'(0));
    n = 0;
    while (n < 100 && (lane_q[2].size() != 0 || m_busy)) begin
      tick(1);
      n++;
    end
    check("t5_req2_done", 32'(n < 100), 32'(1'b1));
    check("t5_ngrants", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      check("t5_g0", 32'(grant_log[0]), 32'(1));
      check("t5_g1", 32'(grant_log[1]), 32'(2));
    end
    lane_q[1].delete();
    hold[1] = 1'b0;
    stall_after[1] = 0;
    tick(2);

    // reset in the middle of a packet from requester 3
    do_reset();
    push_pkt(3, 4);
    n = 0;
    while (n < 50 && lane_q[3].size() == 4) begin
      tick(1);
      n++;
    end
    check("t6_started", 32'(n < 50), 32'(1'b1));
    ack_pct = 0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_rdy", 32'(bus.reply_rdy), 32'(0));
    check("t6_ack", 32'(bus.req_ack), 32'(0));
    check("t6_grant", 32'(grant_id), 32'(N - 1));
    ack_pct = 100;
    tick(2);

    // randomized traffic with lane gaps and host backpressure
    gap_pct = 20;
    ack_pct = 70;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(2));
        for (int p = 0; p < n; p++) push_pkt(i, int'($urandom_range(5, 1)));
      end
      drain("rand", 3000);
      tick(int'($urandom_range(3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
